decode_stage: RTL and testbench

//  Registered instruction-decode stage between the fetch buffer and the execute stage.

---
 rtl/decode_stage.sv | 204 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered MIPS-style decode stage: combinational decode of the incoming word into a
// one-entry valid/ready output register, with load-use hazard stall, flush and stall counting.
module decode_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic              flush,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_alu_ctr,
  output logic              out_reg_wrt,
  output logic              out_mem_read,
  output logic              out_mem_wrt,
  output logic              out_mem_reg,
  output logic              out_alu_src,
  output logic              out_beq,
  output logic              out_bne,
  output logic              out_jump,
  output logic [REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0] out_rt,
  output logic [REG_AW-1:0] out_wr_addr,
  output logic [4:0]        out_shamt,
  output logic [XLEN-1:0]   out_imm,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_LUI = 4'b1010;

  typedef struct packed {
    logic [3:0]        alu;
    logic              reg_wrt;
    logic              mem_read;
    logic              mem_wrt;
    logic              mem_reg;
    logic              alu_src;
    logic              beq;
    logic              bne;
    logic              jump;
    logic              illegal;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] wr;
    logic [4:0]        shamt;
    logic [XLEN-1:0]   imm;
  } dec_t;

  logic [5:0]        w_op, w_funct;
  logic [REG_AW-1:0] w_rs, w_rt, w_rd;
  logic [XLEN-1:0]   w_sext, w_zext;
  logic              w_rt_src, w_haz, w_accept;
  dec_t              w_dec, r_dec;
  logic              r_valid;
  logic [CNT_W-1:0]  r_stall;

  assign w_op    = in_inst[31:26];
  assign w_funct = in_inst[5:0];
  assign w_rs    = REG_AW'(in_inst[25:21]);
  assign w_rt    = REG_AW'(in_inst[20:16]);
  assign w_rd    = REG_AW'(in_inst[15:11]);
  assign w_sext  = {{(XLEN-16){in_inst[15]}}, in_inst[15:0]};
  assign w_zext  = XLEN'(in_inst[15:0]);

  always_comb begin
    w_dec         = '0;
    w_dec.rs      = w_rs;
    w_dec.rt      = w_rt;
    w_dec.wr      = w_rt;
    w_dec.shamt   = in_inst[10:6];
    w_dec.imm     = w_sext;
    case (w_op)
      OP_R: begin
        w_dec.wr      = w_rd;
        w_dec.reg_wrt = 1'b1;
        case (w_funct)
          6'b100000: w_dec.alu = ALU_ADD;
          6'b100010: w_dec.alu = ALU_SUB;
          6'b100100: w_dec.alu = ALU_AND;
          6'b100101: w_dec.alu = ALU_OR;
          6'b101010: w_dec.alu = ALU_SLT;
          6'b000000: w_dec.alu = ALU_SLL;
          6'b000010: w_dec.alu = ALU_SRL;
          default:   w_dec.illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        w_dec.alu      = ALU_ADD;
        w_dec.alu_src  = 1'b1;
        w_dec.reg_wrt  = 1'b1;
        w_dec.mem_read = 1'b1;
        w_dec.mem_reg  = 1'b1;
      end
      OP_SW: begin
        w_dec.alu     = ALU_ADD;
        w_dec.alu_src = 1'b1;
        w_dec.mem_wrt = 1'b1;
      end
      OP_BEQ: begin
        w_dec.alu = ALU_SUB;
        w_dec.beq = 1'b1;
      end
      OP_BNE: begin
        w_dec.alu = ALU_SUB;
        w_dec.bne = 1'b1;
      end
      OP_J: begin
        w_dec.jump = 1'b1;
        w_dec.imm  = XLEN'(in_inst[25:0]);
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        w_dec.alu_src = 1'b1;
        w_dec.reg_wrt = 1'b1;
        case (w_op)
          OP_ADDI: w_dec.alu = ALU_ADD;
          OP_SLTI: w_dec.alu = ALU_SLT;
          OP_ANDI: begin w_dec.alu = ALU_AND; w_dec.imm = w_zext; end
          OP_ORI:  begin w_dec.alu = ALU_OR;  w_dec.imm = w_zext; end
          default: begin w_dec.alu = ALU_LUI; w_dec.imm = XLEN'({in_inst[15:0], 16'h0000}); end
        endcase
      end
      default: w_dec.illegal = 1'b1;
    endcase
    // an illegal word must never write, touch memory or redirect the PC
    if (w_dec.illegal) begin
      w_dec.alu      = ALU_AND;
      w_dec.reg_wrt  = 1'b0;
      w_dec.mem_read = 1'b0;
      w_dec.mem_wrt  = 1'b0;
      w_dec.mem_reg  = 1'b0;
      w_dec.alu_src  = 1'b0;
      w_dec.beq      = 1'b0;
      w_dec.bne      = 1'b0;
      w_dec.jump     = 1'b0;
    end
  end

  assign w_rt_src = (w_op == OP_R) | (w_op == OP_SW) | (w_op == OP_BEQ) | (w_op == OP_BNE);
  assign w_haz    = in_valid & ex_mem_read & (ex_rt != '0) &
                    ((ex_rt == w_rs) | ((ex_rt == w_rt) & w_rt_src));
  assign in_ready = rst_n & ~flush & ~w_haz & (~r_valid | out_ready);
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_dec   <= '0;
      r_stall <= '0;
    end else begin
      if (flush)              r_valid <= 1'b0;
      else if (w_accept) begin
        r_valid <= 1'b1;
        r_dec   <= w_dec;
      end else if (out_ready) r_valid <= 1'b0;
      if (w_haz && !flush && (r_stall != '1))
        r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign out_valid    = r_valid;
  assign out_alu_ctr  = r_dec.alu;
  assign out_reg_wrt  = r_dec.reg_wrt;
  assign out_mem_read = r_dec.mem_read;
  assign out_mem_wrt  = r_dec.mem_wrt;
  assign out_mem_reg  = r_dec.mem_reg;
  assign out_alu_src  = r_dec.alu_src;
  assign out_beq      = r_dec.beq;
  assign out_bne      = r_dec.bne;
  assign out_jump     = r_dec.jump;
  assign out_illegal  = r_dec.illegal;
  assign out_rs       = r_dec.rs;
  assign out_rt       = r_dec.rt;
  assign out_wr_addr  = r_dec.wr;
  assign out_shamt    = r_dec.shamt;
  assign out_imm      = r_dec.imm;
  assign stall_cnt    = r_stall;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes hand-decoded bundles, a monitor pops
// and compares on every output handshake. A CNT_W=2 copy shares the inputs for saturation.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, ex_mem_read, out_valid, out_ready;
  logic [31:0] in_inst;
  logic [4:0]  ex_rt;
  logic [3:0]  out_alu_ctr;
  logic        out_reg_wrt, out_mem_read, out_mem_wrt, out_mem_reg, out_alu_src;
  logic        out_beq, out_bne, out_jump, out_illegal;
  logic [4:0]  out_rs, out_rt, out_wr_addr, out_shamt;
  logic [31:0] out_imm;
  logic [15:0] stall_cnt;

  logic        d_in_ready, d_out_valid, d_reg_wrt, d_mem_read, d_mem_wrt, d_mem_reg;
  logic        d_alu_src, d_beq, d_bne, d_jump, d_illegal;
  logic [3:0]  d_alu;
  logic [4:0]  d_rs, d_rt, d_wr, d_shamt;
  logic [31:0] d_imm;
  logic [1:0]  stall2;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .flush(flush), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .out_valid(out_valid),
    .out_ready(out_ready), .out_alu_ctr(out_alu_ctr), .out_reg_wrt(out_reg_wrt),
    .out_mem_read(out_mem_read), .out_mem_wrt(out_mem_wrt), .out_mem_reg(out_mem_reg),
    .out_alu_src(out_alu_src), .out_beq(out_beq), .out_bne(out_bne), .out_jump(out_jump),
    .out_rs(out_rs), .out_rt(out_rt), .out_wr_addr(out_wr_addr), .out_shamt(out_shamt),
    .out_imm(out_imm), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  decode_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready), .in_inst(in_inst),
    .flush(flush), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .out_valid(d_out_valid),
    .out_ready(out_ready), .out_alu_ctr(d_alu), .out_reg_wrt(d_reg_wrt),
    .out_mem_read(d_mem_read), .out_mem_wrt(d_mem_wrt), .out_mem_reg(d_mem_reg),
    .out_alu_src(d_alu_src), .out_beq(d_beq), .out_bne(d_bne), .out_jump(d_jump),
    .out_rs(d_rs), .out_rt(d_rt), .out_wr_addr(d_wr), .out_shamt(d_shamt),
    .out_imm(d_imm), .out_illegal(d_illegal), .stall_cnt(stall2)
  );

  // ctl = {reg_wrt,mem_read,mem_wrt,mem_reg,alu_src,beq,bne,jump}
  typedef struct packed {
    logic [3:0]  alu;
    logic [7:0]  ctl;
    logic        ill;
    logic [4:0]  rs, rt, wr, sh;
    logic [31:0] imm;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    errs = 0, checks = 0, cyc = 0, c0;
  exp_t  mon_e, act;
  string mon_n;

  always @(posedge clk) cyc <= cyc + 1;

  assign act = '{out_alu_ctr,
                 {out_reg_wrt, out_mem_read, out_mem_wrt, out_mem_reg, out_alu_src, out_beq, out_bne, out_jump},
                 out_illegal, out_rs, out_rt, out_wr_addr, out_shamt, out_imm};

  function automatic exp_t mk(logic [3:0] alu, logic [7:0] ctl, logic ill,
                              logic [4:0] rs, logic [4:0] rt, logic [4:0] wr,
                              logic [4:0] sh, logic [31:0] imm);
    exp_t e;
    e = '{alu, ctl, ill, rs, rt, wr, sh, imm};
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // monitor: one compare per output handshake
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && out_valid && out_ready && !flush) begin
      checks++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL bundle_unexpected: got %h expected none", act);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        if (act !== mon_e) begin
          errs++;
          $display("FAIL bundle_%s: got %h expected %h", mon_n, act, mon_e);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] inst, input exp_t e, input string nm);
    int n = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    @(negedge clk);
    while (!in_ready && n < 20) begin n++; @(negedge clk); end
    if (!in_ready) begin
      checks++; errs++;
      $display("FAIL accept_timeout_%s: got in_ready=0 expected 1 within 20 cycles", nm);
    end else begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 0; in_valid = 1; in_inst = 32'h00221820; out_ready = 1;
    flush = 0; ex_mem_read = 0; ex_rt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready",  32'(in_ready), 0);
    chk("rst_stall",     32'(stall_cnt), 0);
    chk("rst_alu",       32'(out_alu_ctr), 0);
    chk("rst_imm",       out_imm, 0);
    @(posedge clk); #1;
    rst_n = 1; in_valid = 0;
    @(posedge clk); #1;

    // back-to-back stream
    c0 = cyc;
    issue(32'h00221820, mk(4'b0010, 8'b1000_0000, 0, 1, 2, 3, 0, 32'h00001820), "add");
    chk("latency1", 32'(out_valid), 1);
    issue(32'h8C850010, mk(4'b0010, 8'b1101_1000, 0, 4, 5, 5, 0, 32'h00000010), "lw");
    issue(32'h34C7FFFF, mk(4'b0001, 8'b1000_1000, 0, 6, 7, 7, 31, 32'h0000FFFF), "ori");
    issue(32'h1422FFFE, mk(4'b0110, 8'b0000_0010, 0, 1, 2, 2, 31, 32'hFFFFFFFE), "bne");
    chk("stream_cycles", 32'(cyc - c0), 4);

    issue(32'h20098000, mk(4'b0010, 8'b1000_1000, 0, 0, 9, 9, 0, 32'hFFFF8000), "addi");
    issue(32'h3C0A1234, mk(4'b1010, 8'b1000_1000, 0, 0, 10, 10, 8, 32'h12340000), "lui");
    issue(32'hFC000000, mk(4'b0000, 8'b0000_0000, 1, 0, 0, 0, 0, 32'h00000000), "ill_op");
    issue(32'h0000003F, mk(4'b0000, 8'b0000_0000, 1, 0, 0, 0, 0, 32'h0000003F), "ill_funct");
    issue(32'h08000100, mk(4'b0000, 8'b0000_0001, 0, 0, 0, 0, 4, 32'h00000100), "j");
    @(posedge clk); #1;
    @(posedge clk); #1;

    // load-use hazard on rt of SW
    ex_mem_read = 1; ex_rt = 8; in_valid = 1; in_inst = 32'hAC680004;
    repeat (3) begin
      @(negedge clk);
      chk("haz_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk); #1;
    ex_mem_read = 0;
    chk("stall_cnt3", 32'(stall_cnt), 3);
    issue(32'hAC680004, mk(4'b0010, 8'b0010_1000, 0, 3, 8, 8, 0, 32'h00000004), "sw");

    // ex_rt = 0 never stalls
    ex_mem_read = 1; ex_rt = 0;
    c0 = cyc;
    issue(32'hAC680004, mk(4'b0010, 8'b0010_1000, 0, 3, 8, 8, 0, 32'h00000004), "sw_r0");
    chk("no_stall_cycles", 32'(cyc - c0), 1);
    chk("no_stall_cnt", 32'(stall_cnt), 3);
    ex_mem_read = 0;

    // two more stalls via rs: wide counter 5, 2-bit counter saturates at 3
    ex_mem_read = 1; ex_rt = 8; in_valid = 1; in_inst = 32'h11010003;
    repeat (2) @(posedge clk);
    #1;
    ex_mem_read = 0;
    chk("stall_cnt5", 32'(stall_cnt), 5);
    chk("stall_sat", 32'(stall2), 3);
    issue(32'h11010003, mk(4'b0110, 8'b0000_0100, 0, 8, 1, 1, 0, 32'h00000003), "beq");
    @(posedge clk); #1;
    @(posedge clk); #1;

    // backpressure: held bundle stays put, then drain+accept on one edge
    out_ready = 0;
    issue(32'h00222022, mk(4'b0110, 8'b1000_0000, 0, 1, 2, 4, 0, 32'h00002022), "sub");
    in_valid = 1; in_inst = 32'h000228C0;
    repeat (4) begin
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 0);
      chk("full_valid", 32'(out_valid), 1);
      chk("full_imm", out_imm, 32'h00002022);
    end
    @(posedge clk); #1;
    out_ready = 1;
    c0 = cyc;
    issue(32'h000228C0, mk(4'b1000, 8'b1000_0000, 0, 0, 2, 5, 3, 32'h000028C0), "sll");
    chk("no_bubble_cycles", 32'(cyc - c0), 1);
    chk("no_bubble_valid", 32'(out_valid), 1);
    chk("no_bubble_alu", 32'(out_alu_ctr), 32'b1000);
    @(posedge clk); #1;

    // flush discards both the held and the incoming instruction
    out_ready = 0;
    issue(32'h00223024, mk(4'b0000, 8'b1000_0000, 0, 1, 2, 6, 0, 32'h00003024), "and");
    flush = 1; in_valid = 1; in_inst = 32'h08000100;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 0);
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    chk("flush_clears", 32'(out_valid), 0);
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_dropped", 32'(out_valid), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
